// File: rtl/bist_pattern_engine.sv
// BIST stage: LFSR stimulus generator, MISR response compactor and golden-signature compare.
// Optional macro BIST_HOLD_EN adds a HOLD input that freezes the engine while in RUN.
module bist_pattern_engine #(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
    parameter logic [WIDTH-1:0] SEED  = 8'h01,
    parameter int unsigned      NPAT  = 255,
    parameter int unsigned      CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
`ifdef BIST_HOLD_EN
    input  logic             HOLD,
`endif
    input  logic [WIDTH-1:0] RESP,
    input  logic [WIDTH-1:0] GOLD,
    output logic [WIDTH-1:0] PAT,
    output logic [WIDTH-1:0] SIG,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_CMP,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_pat;
    logic [WIDTH-1:0]   r_sig;
    logic [CNT_W-1:0]   r_count;
    logic               r_pass;
    logic               w_hold;
    logic               w_last;
    logic               w_load;
    logic               w_step;
    logic               w_cmp;
    logic [WIDTH-1:0]   w_lfsr_nxt;
    logic [WIDTH-1:0]   w_misr_nxt;

`ifdef BIST_HOLD_EN
    assign w_hold = HOLD;
`else
    assign w_hold = 1'b0;
`endif

    // NPAT may equal 2^CNT_W, so the terminal value NPAT-1 still fits the counter.
    assign w_last     = (r_count == CNT_W'(NPAT - 1));
    assign w_lfsr_nxt = {r_pat[WIDTH-2:0], ^(r_pat & TAPS)};
    assign w_misr_nxt = {r_sig[WIDTH-2:0], ^(r_sig & TAPS)} ^ RESP;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (START) w_state_nxt = S_RUN;
            S_RUN:   if (!w_hold && w_last) w_state_nxt = S_CMP;
            S_CMP:   w_state_nxt = S_DONE;
            S_DONE:  if (START) w_state_nxt = S_RUN;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        BUSY   = 1'b0;
        DONE   = 1'b0;
        w_load = 1'b0;
        w_step = 1'b0;
        w_cmp  = 1'b0;
        case (r_state)
            S_IDLE: w_load = START;
            S_RUN: begin
                BUSY   = 1'b1;
                w_step = !w_hold;
            end
            S_CMP: begin
                BUSY  = 1'b1;
                w_cmp = 1'b1;
            end
            S_DONE: begin
                DONE   = 1'b1;
                w_load = START;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST || w_load) begin
            r_pat   <= SEED;
            r_sig   <= '0;
            r_count <= '0;
            r_pass  <= 1'b0;
        end else if (w_step) begin
            r_pat   <= w_lfsr_nxt;
            r_sig   <= w_misr_nxt;
            r_count <= r_count + 1'b1;
        end else if (w_cmp) begin
            r_pass  <= (r_sig == GOLD);
        end
    end

    assign PAT  = r_pat;
    assign SIG  = r_sig;
    assign PASS = r_pass;

endmodule

// File: tb/tb_bist_pattern_engine.sv
// Directed self-checking bench for bist_pattern_engine (NPAT=255, 4 and 1 instances).
// Builds with or without BIST_HOLD_EN; the hold scenario runs only when it is defined.
module tb_bist_pattern_engine;

    logic       CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Instance a: NPAT=255
    logic       a_rst, a_start, a_hold;
    logic [7:0] a_resp, a_gold, a_pat, a_sig;
    logic       a_busy, a_done, a_pass;
    // Instance b: NPAT=4
    logic       b_rst, b_start, b_hold;
    logic [7:0] b_resp, b_gold, b_pat, b_sig;
    logic       b_busy, b_done, b_pass;
    // Instance c: NPAT=1
    logic       c_rst, c_start, c_hold;
    logic [7:0] c_resp, c_gold, c_pat, c_sig;
    logic       c_busy, c_done, c_pass;

    bist_pattern_engine #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'h01), .NPAT(255), .CNT_W(8)) u_dut_a (
        .CLK(CLK), .RST(a_rst), .START(a_start),
`ifdef BIST_HOLD_EN
        .HOLD(a_hold),
`endif
        .RESP(a_resp), .GOLD(a_gold), .PAT(a_pat), .SIG(a_sig),
        .BUSY(a_busy), .DONE(a_done), .PASS(a_pass)
    );

    bist_pattern_engine #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'h01), .NPAT(4), .CNT_W(8)) u_dut_b (
        .CLK(CLK), .RST(b_rst), .START(b_start),
`ifdef BIST_HOLD_EN
        .HOLD(b_hold),
`endif
        .RESP(b_resp), .GOLD(b_gold), .PAT(b_pat), .SIG(b_sig),
        .BUSY(b_busy), .DONE(b_done), .PASS(b_pass)
    );

    bist_pattern_engine #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'h01), .NPAT(1), .CNT_W(8)) u_dut_c (
        .CLK(CLK), .RST(c_rst), .START(c_start),
`ifdef BIST_HOLD_EN
        .HOLD(c_hold),
`endif
        .RESP(c_resp), .GOLD(c_gold), .PAT(c_pat), .SIG(c_sig),
        .BUSY(c_busy), .DONE(c_done), .PASS(c_pass)
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    logic [7:0] seq [6];
    logic       seen [256];
    int         dups;

    initial begin
        seq = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23};
        for (int i = 0; i < 256; i++) seen[i] = 1'b0;
        dups = 0;
        a_rst = 1'b1; a_start = 1'b0; a_hold = 1'b0; a_resp = 8'h00; a_gold = 8'h00;
        b_rst = 1'b1; b_start = 1'b0; b_hold = 1'b0; b_resp = 8'h00; b_gold = 8'h00;
        c_rst = 1'b1; c_start = 1'b0; c_hold = 1'b0; c_resp = 8'h00; c_gold = 8'h00;
        step();
        step();

        chk("rst_pat",  a_pat, 8'h01);
        chk("rst_sig",  a_sig, 8'h00);
        chk("rst_busy", {7'd0, a_busy}, 8'h00);
        chk("rst_done", {7'd0, a_done}, 8'h00);
        chk("rst_pass", {7'd0, a_pass}, 8'h00);
        a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;

        step();
        chk("idle_hold_busy", {7'd0, a_busy}, 8'h00);

        // Full 255-pattern run, zero response, START pulse injected mid-RUN
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        chk("run_entry_busy", {7'd0, a_busy}, 8'h01);
        chk("lfsr_0", a_pat, seq[0]);
        seen[a_pat] = 1'b1;
        for (int k = 2; k <= 255; k++) begin
            if (k == 10) a_start = 1'b1;
            step();
            a_start = 1'b0;
            if (k <= 6) chk($sformatf("lfsr_%0d", k - 1), a_pat, seq[k-1]);
            if (seen[a_pat] || a_pat == 8'h00) dups++;
            seen[a_pat] = 1'b1;
        end
        chk("lfsr_distinct_dups", 8'(dups), 8'h00);
        step();
        chk("cmp_busy",     {7'd0, a_busy}, 8'h01);
        chk("cmp_not_done", {7'd0, a_done}, 8'h00);
        chk("lfsr_wrap",    a_pat, 8'h01);
        step();
        chk("zero_done_257", {7'd0, a_done}, 8'h01);
        chk("zero_pass",     {7'd0, a_pass}, 8'h01);
        chk("zero_sig",      a_sig, 8'h00);
        step();
        chk("done_hold", {7'd0, a_done}, 8'h01);

        // Restart from DONE, then reset in RUN cycle 3
        a_resp  = 8'h5A;
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        chk("restart_pat",  a_pat, 8'h01);
        chk("restart_pass", {7'd0, a_pass}, 8'h00);
        chk("restart_done", {7'd0, a_done}, 8'h00);
        step();
        chk("misr5a_1", a_sig, 8'h5A);
        step();
        chk("misr5a_2", a_sig, 8'hEE);
        chk("run3_pat", a_pat, 8'h04);
        a_rst = 1'b1;
        step();
        a_rst = 1'b0;
        chk("midrst_pat",  a_pat, 8'h01);
        chk("midrst_sig",  a_sig, 8'h00);
        chk("midrst_busy", {7'd0, a_busy}, 8'h00);
        chk("midrst_done", {7'd0, a_done}, 8'h00);

        // NPAT=4, RESP=FF, START held high -> back-to-back runs
        b_resp  = 8'hFF;
        b_gold  = 8'h05;
        b_start = 1'b1;
        step();
        chk("b_entry_sig", b_sig, 8'h00);
        step(); chk("b_sig_1", b_sig, 8'hFF);
        step(); chk("b_sig_2", b_sig, 8'h01);
        step(); chk("b_sig_3", b_sig, 8'hFD);
        step(); chk("b_sig_4", b_sig, 8'h05);
        chk("b_cmp_done", {7'd0, b_done}, 8'h00);
        step();
        chk("b_done_6",  {7'd0, b_done}, 8'h01);
        chk("b_pass_05", {7'd0, b_pass}, 8'h01);
        step();
        chk("b_rerun_done", {7'd0, b_done}, 8'h00);
        chk("b_rerun_pass", {7'd0, b_pass}, 8'h00);
        chk("b_rerun_pat",  b_pat, 8'h01);
        b_start = 1'b0;
        b_gold  = 8'h04;
        for (int k = 0; k < 5; k++) step();
        chk("b_done_2nd", {7'd0, b_done}, 8'h01);
        chk("b_sig_2nd",  b_sig, 8'h05);
        chk("b_pass_04",  {7'd0, b_pass}, 8'h00);

        // NPAT=1: single RUN cycle
        c_resp  = 8'h3C;
        c_gold  = 8'h3C;
        c_start = 1'b1;
        step();
        c_start = 1'b0;
        step();
        chk("c_sig",      c_sig, 8'h3C);
        chk("c_not_done", {7'd0, c_done}, 8'h00);
        step();
        chk("c_done_3", {7'd0, c_done}, 8'h01);
        chk("c_pass",   {7'd0, c_pass}, 8'h01);

`ifdef BIST_HOLD_EN
        b_gold  = 8'h05;
        b_start = 1'b1;
        step();
        b_start = 1'b0;
        step();
        step();
        chk("h_pre_sig", b_sig, 8'h01);
        b_hold = 1'b1;
        step(); step(); step();
        b_hold = 1'b0;
        chk("h_sig_frozen", b_sig, 8'h01);
        chk("h_pat_frozen", b_pat, 8'h04);
        step(); step();
        chk("h_sig_final", b_sig, 8'h05);
        chk("h_not_done",  {7'd0, b_done}, 8'h00);
        step();
        chk("h_done_9", {7'd0, b_done}, 8'h01);
        chk("h_pass",   {7'd0, b_pass}, 8'h01);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
